// File: rtl/ide_xfer_ring.sv
// rtl/ide_xfer_ring.sv - multi-bank sector ring buffer, byte producer to 16-bit IDE host path
// Optional: define IDE_XFER_RING_BYTESWAP_EN to add the byteswap input (host_data as {lo, hi}).
`timescale 1ns/1ps
module ide_xfer_ring #(
  parameter int NUM_BANKS      = 4,
  parameter int WORDS_PER_BANK = 256,
  parameter int BANK_W         = $clog2(NUM_BANKS),
  parameter int POS_W          = $clog2(WORDS_PER_BANK)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              xfer_start,
  input  logic [7:0]        xfer_banks,
  input  logic [7:0]        prod_data,
  input  logic [POS_W:0]    prod_addr,
  input  logic              prod_strobe,
  input  logic              prod_commit,
  output logic              prod_ready,
  input  logic              host_rd,
`ifdef IDE_XFER_RING_BYTESWAP_EN
  input  logic              byteswap,
`endif
  output logic [15:0]       host_data,
  output logic              host_avail,
  output logic              dmarq,
  output logic              xfer_active,
  output logic              xfer_done,
  output logic              err_overflow,
  output logic              err_underrun,
  output logic [BANK_W:0]   fill_level
);

  localparam int DEPTH = NUM_BANKS * WORDS_PER_BANK;
  localparam logic [BANK_W:0]  FULL     = (BANK_W+1)'(NUM_BANKS);
  localparam logic [POS_W-1:0] LAST_POS = POS_W'(WORDS_PER_BANK - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t              state_q, state_d;
  logic [BANK_W-1:0]   wr_bank_q, wr_bank_d, rd_bank_q, rd_bank_d;
  logic [POS_W-1:0]    rd_pos_q, rd_pos_d;
  logic [BANK_W:0]     full_cnt_q, full_cnt_d;
  logic [8:0]          remaining_q, remaining_d;
  logic                ovf_q, ovf_d, unf_q, unf_d;
  logic                dmarq_q, dmarq_d;
  logic [15:0]         rd_word_q;
  logic                commit_ok, bank_release;

  logic [7:0] mem_lo [DEPTH];
  logic [7:0] mem_hi [DEPTH];
  logic [BANK_W+POS_W-1:0] wr_addr, rd_addr;

  assign wr_addr = {wr_bank_q, prod_addr[POS_W:1]};
  assign rd_addr = {rd_bank_q, rd_pos_q};

  always_ff @(posedge clk) begin
    if (prod_strobe) begin
      if (prod_addr[0]) mem_hi[wr_addr] <= prod_data;
      else              mem_lo[wr_addr] <= prod_data;
    end
  end

  // Prefetch register: always tracks the current read position, one cycle behind.
  always_ff @(posedge clk) begin
    if (rst) rd_word_q <= '0;
    else     rd_word_q <= {mem_hi[rd_addr], mem_lo[rd_addr]};
  end

  assign host_avail   = (state_q == RUN) && (full_cnt_q != '0);
  assign commit_ok    = prod_commit && (full_cnt_q != FULL);
  assign bank_release = host_rd && host_avail && (rd_pos_q == LAST_POS);

  always_comb begin
    state_d     = state_q;
    wr_bank_d   = wr_bank_q;
    rd_bank_d   = rd_bank_q;
    rd_pos_d    = rd_pos_q;
    full_cnt_d  = full_cnt_q;
    remaining_d = remaining_q;
    ovf_d       = ovf_q;
    unf_d       = unf_q;

    case (state_q)
      IDLE: if (xfer_start) begin
        state_d     = RUN;
        remaining_d = (xfer_banks == 8'd0) ? 9'd256 : {1'b0, xfer_banks};
        rd_pos_d    = '0;
        ovf_d       = 1'b0;
        unf_d       = 1'b0;
      end
      RUN:  if (bank_release && (remaining_q == 9'd1)) state_d = DONE;
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (host_rd) begin
      if (host_avail) rd_pos_d = rd_pos_q + POS_W'(1);
      else            unf_d    = 1'b1;
    end
    if (bank_release) begin
      rd_bank_d   = rd_bank_q + BANK_W'(1);
      remaining_d = remaining_q - 9'd1;
    end
    if (commit_ok)                 wr_bank_d = wr_bank_q + BANK_W'(1);
    if (prod_commit && !commit_ok) ovf_d     = 1'b1;

    if (commit_ok && !bank_release)      full_cnt_d = full_cnt_q + (BANK_W+1)'(1);
    else if (!commit_ok && bank_release) full_cnt_d = full_cnt_q - (BANK_W+1)'(1);

    // Rises one cycle after RUN+full; drops right after the releasing read unless more data follows.
    dmarq_d = host_avail && (state_d == RUN) && (full_cnt_d != '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      wr_bank_q   <= '0;
      rd_bank_q   <= '0;
      rd_pos_q    <= '0;
      full_cnt_q  <= '0;
      remaining_q <= '0;
      ovf_q       <= 1'b0;
      unf_q       <= 1'b0;
      dmarq_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_bank_q   <= wr_bank_d;
      rd_bank_q   <= rd_bank_d;
      rd_pos_q    <= rd_pos_d;
      full_cnt_q  <= full_cnt_d;
      remaining_q <= remaining_d;
      ovf_q       <= ovf_d;
      unf_q       <= unf_d;
      dmarq_q     <= dmarq_d;
    end
  end

`ifdef IDE_XFER_RING_BYTESWAP_EN
  logic swap_q;
  always_ff @(posedge clk) begin
    if (rst)                              swap_q <= 1'b0;
    else if (state_q == IDLE && xfer_start) swap_q <= byteswap;
  end
  assign host_data = swap_q ? {rd_word_q[7:0], rd_word_q[15:8]} : rd_word_q;
`else
  assign host_data = rd_word_q;
`endif

  assign prod_ready   = (full_cnt_q != FULL);
  assign dmarq        = dmarq_q;
  assign xfer_active  = (state_q == RUN);
  assign xfer_done    = (state_q == DONE);
  assign err_overflow = ovf_q;
  assign err_underrun = unf_q;
  assign fill_level   = full_cnt_q;

endmodule

// File: tb/tb_ide_xfer_ring.sv
// tb/tb_ide_xfer_ring.sv - directed self-checking bench for ide_xfer_ring
`timescale 1ns/1ps
module tb_ide_xfer_ring;

  logic        clk = 1'b0;
  logic        rst, xfer_start, prod_strobe, prod_commit, host_rd;
  logic [7:0]  xfer_banks, prod_data;
  logic [8:0]  prod_addr;
  logic        prod_ready, host_avail, dmarq, xfer_active, xfer_done;
  logic        err_overflow, err_underrun;
  logic [15:0] host_data;
  logic [2:0]  fill_level;
`ifdef IDE_XFER_RING_BYTESWAP_EN
  logic        byteswap;
`endif

  int n_cmp = 0;
  int n_err = 0;
  int done_seen;

  always #5 clk = ~clk;

  ide_xfer_ring #(.NUM_BANKS(4), .WORDS_PER_BANK(256)) dut (
    .clk(clk), .rst(rst), .xfer_start(xfer_start), .xfer_banks(xfer_banks),
    .prod_data(prod_data), .prod_addr(prod_addr), .prod_strobe(prod_strobe),
    .prod_commit(prod_commit), .prod_ready(prod_ready), .host_rd(host_rd),
`ifdef IDE_XFER_RING_BYTESWAP_EN
    .byteswap(byteswap),
`endif
    .host_data(host_data), .host_avail(host_avail), .dmarq(dmarq),
    .xfer_active(xfer_active), .xfer_done(xfer_done), .err_overflow(err_overflow),
    .err_underrun(err_underrun), .fill_level(fill_level)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] exp_word(input int mode, input int bank, input int w);
    case (mode)
      0:       return {8'(2*w+1), 8'(2*w)};
      1:       return 16'hA5A5;
      2:       return 16'hB000 + 16'(w);
      default: return {8'(bank), 8'(w)};
    endcase
  endfunction

  task automatic do_reset();
    rst = 1'b1; xfer_start = 1'b0; prod_strobe = 1'b0; prod_commit = 1'b0;
    host_rd = 1'b0; xfer_banks = 8'd0; prod_data = 8'd0; prod_addr = 9'd0;
`ifdef IDE_XFER_RING_BYTESWAP_EN
    byteswap = 1'b0;
`endif
    tick(); tick();
  endtask

  task automatic wr_byte(input int addr, input logic [7:0] d);
    prod_addr = 9'(addr); prod_data = d; prod_strobe = 1'b1;
    tick();
    prod_strobe = 1'b0;
  endtask

  task automatic fill_bank(input int mode, input int bank);
    logic [15:0] wd;
    for (int w = 0; w < 256; w++) begin
      wd = exp_word(mode, bank, w);
      wr_byte(2*w, wd[7:0]);
      wr_byte(2*w+1, wd[15:8]);
    end
  endtask

  task automatic commit();
    prod_commit = 1'b1; tick(); prod_commit = 1'b0;
  endtask

  task automatic start(input logic [7:0] nb);
    xfer_banks = nb; xfer_start = 1'b1; tick(); xfer_start = 1'b0;
  endtask

  task automatic host_read();
    host_rd = 1'b1; tick();
    if (xfer_done) done_seen++;
    host_rd = 1'b0; tick();
    if (xfer_done) done_seen++;
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++; if (prod_ready !== 1'b1) begin n_err++; $display("FAIL reset_prod_ready got %b want 1", prod_ready); end
    n_cmp++; if ({host_avail, dmarq, xfer_active, xfer_done, err_overflow, err_underrun} !== 6'b0) begin
      n_err++; $display("FAIL reset_flags got %b want 000000",
                        {host_avail, dmarq, xfer_active, xfer_done, err_overflow, err_underrun}); end
    n_cmp++; if (fill_level !== 3'd0) begin n_err++; $display("FAIL reset_fill got %0d want 0", fill_level); end
    n_cmp++; if (host_data !== 16'h0) begin n_err++; $display("FAIL reset_host_data got %h want 0000", host_data); end
    rst = 1'b0;
  endtask

  task automatic test_two_bank_xfer();
    logic [15:0] e;
    do_reset(); rst = 1'b0;
    fill_bank(0, 0); commit();
    fill_bank(1, 1); commit();
    n_cmp++; if (fill_level !== 3'd2) begin n_err++; $display("FAIL t1_fill_pre got %0d want 2", fill_level); end
    start(8'd2); tick();
    done_seen = 0;
    for (int w = 0; w < 512; w++) begin
      e = (w < 256) ? exp_word(0, 0, w) : exp_word(1, 1, w - 256);
      n_cmp++; if (host_data !== e) begin n_err++; $display("FAIL t1_data[%0d] got %h want %h", w, host_data, e); end
      n_cmp++; if (dmarq !== 1'b1) begin n_err++; $display("FAIL t1_dmarq[%0d] got %b want 1", w, dmarq); end
      host_read();
    end
    n_cmp++; if (done_seen !== 1) begin n_err++; $display("FAIL t1_done_pulses got %0d want 1", done_seen); end
    n_cmp++; if (fill_level !== 3'd0) begin n_err++; $display("FAIL t1_fill_post got %0d want 0", fill_level); end
    n_cmp++; if ({xfer_active, dmarq} !== 2'b00) begin n_err++; $display("FAIL t1_idle got %b want 00", {xfer_active, dmarq}); end
  endtask

  task automatic test_underrun();
    do_reset(); rst = 1'b0;
    fill_bank(0, 0); commit();
    start(8'd3); tick();
    for (int w = 0; w < 256; w++) host_read();
    n_cmp++; if (dmarq !== 1'b0) begin n_err++; $display("FAIL t2_dmarq_fall got %b want 0", dmarq); end
    n_cmp++; if (host_avail !== 1'b0) begin n_err++; $display("FAIL t2_avail got %b want 0", host_avail); end
    n_cmp++; if (err_underrun !== 1'b0) begin n_err++; $display("FAIL t2_unf_early got %b want 0", err_underrun); end
    host_read();
    n_cmp++; if (err_underrun !== 1'b1) begin n_err++; $display("FAIL t2_underrun got %b want 1", err_underrun); end
    fill_bank(2, 1); commit(); tick();
    n_cmp++; if ({dmarq, host_avail} !== 2'b11) begin n_err++; $display("FAIL t2_resume got %b want 11", {dmarq, host_avail}); end
    n_cmp++; if (host_data !== 16'hB000) begin n_err++; $display("FAIL t2_word0 got %h want b000", host_data); end
    host_read();
    n_cmp++; if (host_data !== 16'hB001) begin n_err++; $display("FAIL t2_word1 got %h want b001", host_data); end
  endtask

  task automatic test_overflow();
    do_reset(); rst = 1'b0;
    for (int i = 0; i < 4; i++) commit();
    n_cmp++; if (prod_ready !== 1'b0) begin n_err++; $display("FAIL t3_ready got %b want 0", prod_ready); end
    n_cmp++; if (err_overflow !== 1'b0) begin n_err++; $display("FAIL t3_ovf_early got %b want 0", err_overflow); end
    commit();
    n_cmp++; if (err_overflow !== 1'b1) begin n_err++; $display("FAIL t3_overflow got %b want 1", err_overflow); end
    n_cmp++; if (fill_level !== 3'd4) begin n_err++; $display("FAIL t3_fill got %0d want 4", fill_level); end
  endtask

  task automatic test_commit_release_same_cycle();
    do_reset(); rst = 1'b0;
    commit();
    fill_bank(3, 1); commit();
    start(8'd4); tick();
    for (int w = 0; w < 255; w++) host_read();
    host_rd = 1'b1; prod_commit = 1'b1; tick();
    host_rd = 1'b0; prod_commit = 1'b0; tick();
    n_cmp++; if (fill_level !== 3'd2) begin n_err++; $display("FAIL t4_fill got %0d want 2", fill_level); end
    n_cmp++; if (dut.wr_bank_q !== 2'd3) begin n_err++; $display("FAIL t4_wr_bank got %0d want 3", dut.wr_bank_q); end
    n_cmp++; if (dut.rd_bank_q !== 2'd1) begin n_err++; $display("FAIL t4_rd_bank got %0d want 1", dut.rd_bank_q); end
    n_cmp++; if (host_data !== 16'h0100) begin n_err++; $display("FAIL t4_data got %h want 0100", host_data); end
    n_cmp++; if (dmarq !== 1'b1) begin n_err++; $display("FAIL t4_dmarq got %b want 1", dmarq); end
  endtask

  task automatic test_mid_reset();
    do_reset(); rst = 1'b0;
    for (int i = 0; i < 3; i++) commit();
    start(8'd3); tick();
    for (int w = 0; w < 100; w++) host_read();
    rst = 1'b1; tick(); rst = 1'b0;
    n_cmp++; if ({xfer_active, dmarq} !== 2'b00) begin n_err++; $display("FAIL t5_flags got %b want 00", {xfer_active, dmarq}); end
    n_cmp++; if (fill_level !== 3'd0) begin n_err++; $display("FAIL t5_fill got %0d want 0", fill_level); end
    n_cmp++; if (host_data !== 16'h0) begin n_err++; $display("FAIL t5_host_data got %h want 0000", host_data); end
    start(8'd0);
    n_cmp++; if (dut.remaining_q !== 9'd256) begin n_err++; $display("FAIL t5_remaining got %0d want 256", dut.remaining_q); end
    n_cmp++; if (xfer_active !== 1'b1) begin n_err++; $display("FAIL t5_active got %b want 1", xfer_active); end
  endtask

  task automatic test_byteswap();
    logic [15:0] e;
    do_reset(); rst = 1'b0;
    wr_byte(0, 8'h34); wr_byte(1, 8'h12); commit();
`ifdef IDE_XFER_RING_BYTESWAP_EN
    byteswap = 1'b1;
    e = 16'h3412;
`else
    e = 16'h1234;
`endif
    start(8'd1); tick();
    n_cmp++; if (host_data !== e) begin n_err++; $display("FAIL t6_byteswap got %h want %h", host_data, e); end
  endtask

  initial begin
    test_reset();
    test_two_bank_xfer();
    test_underrun();
    test_overflow();
    test_commit_release_same_cycle();
    test_mid_reset();
    test_byteswap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
